// File: rtl/resp_out_queue_if.sv
// rtl/resp_out_queue_if.sv - response input, head presentation and status bundle for resp_out_queue
interface resp_out_queue_if #(
    parameter int CW = 3
);
    logic [0:31]   req_data;
    logic [0:1]    req_resp;
    logic [0:31]   out_data;
    logic [0:1]    out_resp;
    logic          out_ack;
    logic          full;
    logic [0:CW-1] count;
    logic [0:7]    drop_cnt;

    modport master (
        output req_data, req_resp, out_ack,
        input  out_data, out_resp, full, count, drop_cnt
    );

    modport slave (
        input  req_data, req_resp, out_ack,
        output out_data, out_resp, full, count, drop_cnt
    );
endinterface

// File: rtl/resp_out_queue.sv
// rtl/resp_out_queue.sv - response FIFO with hold-until-ack head and drop counter (RESP_STATS_EN)
module resp_out_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic             c_clk,
    input  logic             reset,
    resp_out_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [0:31]   mem_data [DEPTH];
    logic [0:1]    mem_resp [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ;

    logic push;
    logic pop;
    logic is_full;
    logic accept;

    assign push    = (bus.req_resp != 2'b00);
    assign pop     = bus.out_ack && (occ != '0);
    assign is_full = (occ == CW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign accept  = push && (!is_full || pop);

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (accept && !pop) begin
                occ <= occ + CW'(1);
            end else if (pop && !accept) begin
                occ <= occ - CW'(1);
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset && accept) begin
            mem_data[wr_ptr] <= bus.req_data;
            mem_resp[wr_ptr] <= bus.req_resp;
        end
    end

    always_comb begin
        bus.out_data = '0;
        bus.out_resp = 2'b00;
        if (occ != '0) begin
            bus.out_data = mem_data[rd_ptr];
            bus.out_resp = mem_resp[rd_ptr];
        end
    end

    assign bus.full  = is_full;
    assign bus.count = occ;

`ifdef RESP_STATS_EN
    logic [7:0] drop_q;

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            drop_q <= '0;
        end else if (push && is_full && !pop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = '0;
`endif
endmodule

// File: tb/tb_resp_out_queue.sv
// tb/tb_resp_out_queue.sv - directed bench for resp_out_queue with a queue-based reference model
module tb_resp_out_queue;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic c_clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    resp_out_queue_if #(.CW(CW)) bus ();

    resp_out_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 c_clk = ~c_clk;

    // Reference: an ordered list of {resp, data} plus a drop tally.
    logic [33:0] mq [$];
    int          m_drop = 0;

    always @(posedge c_clk) begin
        bit m_pop;
        bit m_push;
        if (!reset) begin
            mq.delete();
            m_drop = 0;
        end else begin
            m_pop  = bus.out_ack && (mq.size() > 0);
            m_push = (bus.req_resp != 2'b00);
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                if (mq.size() < DEPTH) mq.push_back({bus.req_resp, bus.req_data});
                else if (STATS && m_drop < 255) m_drop++;
            end
        end
    end

    always @(negedge c_clk) begin
        logic [1:0]  e_resp;
        logic [31:0] e_data;
        if (chk_en) begin
            e_resp = (mq.size() > 0) ? mq[0][33:32] : 2'b00;
            e_data = (mq.size() > 0) ? mq[0][31:0]  : 32'd0;
            checks++;
            if (bus.out_resp !== e_resp || bus.out_data !== e_data ||
                32'(bus.count) !== 32'(mq.size()) || bus.full !== (mq.size() == DEPTH) ||
                32'(bus.drop_cnt) !== 32'(m_drop)) begin
                errors++;
                $display("FAIL model t=%0t got resp=%b data=%0d count=%0d full=%b drop=%0d want resp=%b data=%0d count=%0d full=%b drop=%0d",
                         $time, bus.out_resp, bus.out_data, bus.count, bus.full, bus.drop_cnt,
                         e_resp, e_data, mq.size(), (mq.size() == DEPTH), m_drop);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] r, input logic [31:0] d, input logic a, input logic rst = 1'b1);
        @(negedge c_clk);
        bus.req_resp = r;
        bus.req_data = d;
        bus.out_ack  = a;
        reset        = rst;
        @(posedge c_clk);
        #1;
    endtask

    task automatic head(input string name, input logic [1:0] r, input logic [31:0] d, input int c);
        check({name, "_resp"},  32'(bus.out_resp), 32'(r));
        check({name, "_data"},  bus.out_data, d);
        check({name, "_count"}, 32'(bus.count), 32'(c));
    endtask

    initial begin
        bus.req_resp = 2'b00;
        bus.req_data = '0;
        bus.out_ack  = 1'b0;
        step(2'b00, 0, 0, 1'b0);
        step(2'b00, 0, 0, 1'b0);
        chk_en = 1'b1;
        check("rst_full", 32'(bus.full), 0);
        check("rst_drop", 32'(bus.drop_cnt), 0);
        head("rst", 2'b00, 0, 0);

        // single push then ack
        step(2'b01, 4096, 0);
        head("single", 2'b01, 4096, 1);
        step(2'b00, 0, 1);
        head("single_pop", 2'b00, 0, 0);

        // fill, overflow drop, drain in order
        step(2'b10, 1, 0);
        step(2'b01, 2, 0);
        step(2'b11, 3, 0);
        step(2'b01, 4, 0);
        check("fill_full", 32'(bus.full), 1);
        step(2'b01, 5, 0);
        check("ovf_count", 32'(bus.count), 4);
        check("ovf_drop", 32'(bus.drop_cnt), STATS ? 1 : 0);
        head("drain0", 2'b10, 1, 4);
        step(2'b00, 0, 1);
        head("drain1", 2'b01, 2, 3);
        step(2'b00, 0, 1);
        head("drain2", 2'b11, 3, 2);
        step(2'b00, 0, 1);
        head("drain3", 2'b01, 4, 1);
        step(2'b00, 0, 1);
        head("drain4", 2'b00, 0, 0);

        // full queue with simultaneous push and pop
        for (int i = 0; i < 4; i++) step(2'b01, 11 + i, 0);
        step(2'b01, 1234, 1);
        head("fpp", 2'b01, 12, 4);
        check("fpp_drop", 32'(bus.drop_cnt), STATS ? 1 : 0);
        step(2'b00, 0, 1);
        step(2'b00, 0, 1);
        step(2'b00, 0, 1);
        head("fpp_last", 2'b01, 1234, 1);
        step(2'b00, 0, 1);
        head("fpp_empty", 2'b00, 0, 0);

        // empty queue, push with ack: no bypass
        step(2'b01, 7, 1);
        head("nobyp", 2'b01, 7, 1);
        step(2'b00, 0, 0);
        step(2'b00, 0, 0);
        head("nobyp_hold", 2'b01, 7, 1);
        step(2'b00, 0, 1);
        head("nobyp_pop", 2'b00, 0, 0);

        // mid-operation reset with coinciding push, then a code-00 cycle
        step(2'b01, 21, 0);
        step(2'b10, 22, 0);
        step(2'b11, 23, 0);
        step(2'b01, 24, 1, 1'b0);
        head("mrst", 2'b00, 0, 0);
        check("mrst_full", 32'(bus.full), 0);
        check("mrst_drop", 32'(bus.drop_cnt), 0);
        step(2'b00, 99, 0);
        head("nopush", 2'b00, 0, 0);

        // pointer wrap with interleaved push/pop
        step(2'b01, 200, 0);
        for (int i = 0; i < 10; i++) begin
            step(2'b01, 100 + i, 1);
            check("wrap_count", 32'(bus.count), 1);
        end
        head("wrap_head", 2'b01, 109, 1);
        step(2'b00, 0, 1);
        head("wrap_end", 2'b00, 0, 0);

        // drop saturation
        for (int i = 0; i < 4; i++) step(2'b01, 300 + i, 0);
        for (int i = 0; i < 300; i++) step(2'b10, i, 0);
        check("sat_drop", 32'(bus.drop_cnt), STATS ? 255 : 0);
        head("sat_head", 2'b01, 300, 4);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/resp_out_queue.md
# resp_out_queue

- Response output stage downstream of the two-responder response mux.
- Captures every merged response (`req_data`, `req_resp`) the mux produces and buffers it in a small FIFO.
- Presents responses one at a time to the requesting port under a hold-until-acknowledged handshake, so the port never loses back-to-back responses.
- Counts responses dropped because the queue was full.

## Interface

Parameters:
- `DEPTH`, default 4: number of buffered responses; power of two, 2..16.
- `CW`, default 3: occupancy counter width, equal to log2(`DEPTH`)+1.

Ports:
- `c_clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low reset, sampled on the `c_clk` rising edge.
- `req_data`  in  [0:31]: merged response data from the mux; bit 0 is the MSB.
- `req_resp`  in  [0:1]: merged response code. 00 = none, 01 = success, 10 = overflow/underflow, 11 = invalid command.
- `out_data`  out  [0:31]: data of the head entry.
- `out_resp`  out  [0:1]: code of the head entry; 00 when the queue is empty.
- `out_ack`  in  1: consumer accepts the presented response this cycle.
- `full`  out  1: occupancy equals `DEPTH`.
- `count`  out  [0:CW-1]: current occupancy.
- `drop_cnt`  out  [0:7]: saturating count of dropped responses (see Configuration).

## Operation

- Push: any cycle with `req_resp` != 00 is a push of {`req_data`, `req_resp`}. `req_resp` = 00 is never stored, whatever `req_data` holds.
- Pop: any cycle with `out_ack`=1 and occupancy > 0. `out_ack` on an empty queue is ignored: no state change, no error.
- Storage: circular buffer with write and read pointers of log2(`DEPTH`) bits. Pointers wrap modulo `DEPTH`. Occupancy is tracked in `count`.
- Head presentation:
  - `out_resp`/`out_data` are driven from the entry at the read pointer whenever `count` > 0.
  - When the queue is empty, `out_resp` = 00 and `out_data` = 0.
  - The head holds stable until popped.
- Full, push, no pop: the push is dropped, the contents are unchanged, and `drop_cnt` increments.
- Full, push and pop in the same cycle: both are accepted; `count` stays `DEPTH`.
- Empty, push and `out_ack` in the same cycle: the push is accepted, the ack is ignored, and `count` becomes 1. There is no bypass.
- Pop and push, not full: both are performed; `count` is unchanged.
- Code 11 and code 10 entries are queued exactly like success; no filtering.

## Timing

- Reset, with `reset`=0 at an edge:
  - Next cycle: `count`=0, pointers=0, `full`=0, `out_resp`=00, `out_data`=0, `drop_cnt`=0.
  - Applies mid-operation: all buffered entries are discarded.
  - A push or ack coinciding with reset is ignored.
- Latency: a push sampled at edge N is visible on `out_resp`/`out_data` after edge N (cycle N+1) when it is the new head. With k entries ahead of it, it is visible one cycle after the k-th pop.
- Pop at edge N: the next entry, or 00/0 if none, is presented from cycle N+1.
- `full` and `count` are registered and reflect state after the most recent edge.
- Throughput: one push and one pop per cycle sustained.

## Configuration

- Macro: `RESP_STATS_EN`.
- Defined:
  - `drop_cnt` increments by 1 on every dropped push.
  - It saturates at 255 and clears only on reset.
- Undefined:
  - The counter logic is not built.
  - `drop_cnt` is tied to 0.
  - The port list is unchanged.
  - Full-queue drops still occur silently.

## Test plan

- Reset, then a single push: `req_resp`=01, `req_data`=4096 → next cycle `out_resp`=01, `out_data`=4096, `count`=1. Ack → following cycle `out_resp`=00, `count`=0.
- Four pushes without ack (01/10, 02/01, 03/11, 04/01) → `full`=1. Fifth push 05/01 → `count`=4, `drop_cnt`=1. Four acks return data 1, 2, 3, 4 with codes 10, 01, 11, 01 in order.
- Full queue, push 1234/01 plus ack in the same cycle → `count` stays 4, head advances, `drop_cnt` unchanged, 1234 emerges last.
- Empty queue, push 7/01 with `out_ack`=1 in the same cycle → `count`=1, `out_data`=7 held until a later ack.
- Queue holding 3 entries, `reset`=0 for one cycle → `out_resp`=00, `count`=0, `full`=0, `drop_cnt`=0. `req_resp`=00 with `req_data`=99 → no push.
- Pointer wrap: 10 pushes and pops interleaved → output order matches input order. With `RESP_STATS_EN`: 300 drops → `drop_cnt`=255.
